// File: rtl/f_pc_ctrl_pkg.sv
// Shared constants, FSM encoding and branch-offset helper for the fetch PC controller.
package f_pc_ctrl_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned IMM16 = 16;
    localparam int unsigned IMM26 = 26;

    localparam logic [XLEN-1:0] PC_RESET = 32'h0000_3000;
    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    // Word offset of a branch: sign-extended immediate scaled by 4.
    function automatic logic [XLEN-1:0] br_offset(input logic [IMM16-1:0] imm);
        return {{(XLEN-IMM16-2){imm[IMM16-1]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// D-stage next-PC target selection and redirect request (purely combinational).
module npc_calc
    import f_pc_ctrl_pkg::*;
(
    input  logic             stall,
    input  logic             D_valid,
    input  logic             D_is_beq,
    input  logic             D_is_bne,
    input  logic             D_is_j,
    input  logic             D_is_jr,
    input  logic             Beq_judge,
    input  logic             Bne_judge,
    input  logic [XLEN-1:0]  D_PC,
    input  logic [IMM16-1:0] D_imm16,
    input  logic [IMM26-1:0] D_imm26,
    input  logic [XLEN-1:0]  D_rs_data,
    output logic [XLEN-1:0]  target_c,
    output logic             redirect_req_c
);

    logic [XLEN-1:0] pc_plus4;
    logic            taken;

    assign pc_plus4 = D_PC + PC_STEP;

    // A stalled D stage never redirects; it re-presents the instruction later.
    always_comb begin
        taken          = (D_is_beq & Beq_judge) | (D_is_bne & Bne_judge) | D_is_j | D_is_jr;
        redirect_req_c = D_valid & ~stall & taken;
    end

    always_comb begin
        target_c = pc_plus4 + br_offset(D_imm16);
        if (D_is_jr) begin
            target_c = D_rs_data;
        end else if (D_is_j) begin
            target_c = {pc_plus4[XLEN-1:XLEN-4], D_imm26, 2'b00};
        end
    end

endmodule

// File: rtl/f_pc_ctrl.sv
// Fetch PC register with one-delay-slot redirect handling and a RUN/PEND capture FSM.
module f_pc_ctrl
    import f_pc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             D_valid,
    input  logic             D_is_beq,
    input  logic             D_is_bne,
    input  logic             D_is_j,
    input  logic             D_is_jr,
    input  logic             Beq_judge,
    input  logic             Bne_judge,
    input  logic [XLEN-1:0]  D_PC,
    input  logic [IMM16-1:0] D_imm16,
    input  logic [IMM26-1:0] D_imm26,
    input  logic [XLEN-1:0]  D_rs_data,
    output logic [XLEN-1:0]  F_PC,
    output logic             F_fire,
    output logic             redirect_pending
);

    state_t          state;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] target_c;
    logic            redirect_req_c;

    npc_calc u_npc_calc (
        .stall          (stall),
        .D_valid        (D_valid),
        .D_is_beq       (D_is_beq),
        .D_is_bne       (D_is_bne),
        .D_is_j         (D_is_j),
        .D_is_jr        (D_is_jr),
        .Beq_judge      (Beq_judge),
        .Bne_judge      (Bne_judge),
        .D_PC           (D_PC),
        .D_imm16        (D_imm16),
        .D_imm26        (D_imm26),
        .D_rs_data      (D_rs_data),
        .target_c       (target_c),
        .redirect_req_c (redirect_req_c)
    );

    assign F_fire           = imem_ready & ~stall;
    assign redirect_pending = (state == PEND);

    // The redirect lands on the fetch after the delay slot; if the delay slot
    // fetch has not completed yet, the target is parked in pend_target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            F_PC        <= PC_RESET;
            pend_target <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (F_fire) begin
                        F_PC <= redirect_req_c ? target_c : F_PC + PC_STEP;
                    end else if (redirect_req_c) begin
                        pend_target <= target_c;
                        state       <= PEND;
                    end
                end
                PEND: begin
                    if (F_fire) begin
                        F_PC  <= pend_target;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Self-checking bench for f_pc_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_f_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset, stall, imem_ready, D_valid;
    logic        D_is_beq, D_is_bne, D_is_j, D_is_jr, Beq_judge, Bne_judge;
    logic [31:0] D_PC, D_rs_data;
    logic [15:0] D_imm16;
    logic [25:0] D_imm26;
    logic [31:0] F_PC;
    logic        F_fire, redirect_pending;

    int unsigned passed = 0;
    int unsigned total  = 0;

    // Reference model: architectural PC and a queue of at most one waiting target.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];

    f_pc_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .imem_ready       (imem_ready),
        .D_valid          (D_valid),
        .D_is_beq         (D_is_beq),
        .D_is_bne         (D_is_bne),
        .D_is_j           (D_is_j),
        .D_is_jr          (D_is_jr),
        .Beq_judge        (Beq_judge),
        .Bne_judge        (Bne_judge),
        .D_PC             (D_PC),
        .D_imm16          (D_imm16),
        .D_imm26          (D_imm26),
        .D_rs_data        (D_rs_data),
        .F_PC             (F_PC),
        .F_fire           (F_fire),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    function automatic logic m_fire();
        return imem_ready && !stall;
    endfunction

    function automatic logic m_redirect();
        return D_valid && !stall &&
               ((D_is_beq && Beq_judge) || (D_is_bne && Bne_judge) || D_is_j || D_is_jr);
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] seq;
        seq = D_PC + 32'd4;
        if (D_is_jr) return D_rs_data;
        if (D_is_j)  return (seq & 32'hF000_0000) | (32'(D_imm26) * 32'd4);
        return seq + 32'($signed(D_imm16)) * 32'd4;
    endfunction

    // Advance the model with the current inputs, then clock the DUT; returns at the negedge.
    task automatic tick();
        if (reset) begin
            m_pc = 32'h0000_3000;
            m_q.delete();
        end else if (m_q.size() == 0) begin
            if (m_fire())          m_pc = m_redirect() ? m_target() : m_pc + 32'd4;
            else if (m_redirect()) m_q.push_back(m_target());
        end else if (m_fire()) begin
            m_pc = m_q.pop_front();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_d();
        D_valid = 0; D_is_beq = 0; D_is_bne = 0; D_is_j = 0; D_is_jr = 0;
        Beq_judge = 0; Bne_judge = 0;
        D_PC = '0; D_imm16 = '0; D_imm26 = '0; D_rs_data = '0;
    endtask

    task automatic do_reset();
        reset = 1; stall = 0; imem_ready = 1; clear_d();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; imem_ready = 1; clear_d();
        tick(); tick();
        total++;
        if (F_PC !== 32'h0000_3000) $display("FAIL reset_pc: got %h want 00003000", F_PC);
        else passed++;
        total++;
        if (redirect_pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", redirect_pending);
        else passed++;
        reset = 0;
        #1;
        total++;
        if (F_fire !== 1'b1) $display("FAIL reset_fire: got %b want 1", F_fire);
        else passed++;
        tick();
        total++;
        if (F_PC !== 32'h0000_3004) $display("FAIL reset_release_pc: got %h want 00003004", F_PC);
        else passed++;
    endtask

    task automatic test_beq_taken();
        do_reset();
        D_valid = 1; D_is_beq = 1; Beq_judge = 1; D_PC = 32'h0000_3000; D_imm16 = 16'h0003;
        tick();
        total++;
        if (F_PC !== 32'h0000_3010) $display("FAIL beq_taken: got %h want 00003010", F_PC);
        else passed++;
        // Not-taken beq behaves as plain sequential fetch.
        Beq_judge = 0;
        tick();
        total++;
        if (F_PC !== 32'h0000_3014) $display("FAIL beq_not_taken: got %h want 00003014", F_PC);
        else passed++;
        clear_d();
    endtask

    task automatic test_bne_wrap();
        do_reset();
        D_valid = 1; D_is_bne = 1; Bne_judge = 1; D_PC = 32'h0000_3008; D_imm16 = 16'hFFFE;
        tick();
        total++;
        if (F_PC !== 32'h0000_3004) $display("FAIL bne_backward: got %h want 00003004", F_PC);
        else passed++;
        D_PC = 32'hFFFF_FFF8; D_imm16 = 16'h0000;
        tick();
        total++;
        if (F_PC !== 32'hFFFF_FFFC) $display("FAIL bne_wrap: got %h want fffffffc", F_PC);
        else passed++;
        D_is_bne = 0; D_is_j = 1; D_PC = 32'hA000_1000; D_imm26 = 26'h0000_123;
        tick();
        total++;
        if (F_PC !== 32'hA000_048C) $display("FAIL j_target: got %h want a000048c", F_PC);
        else passed++;
        clear_d();
    endtask

    task automatic test_pending();
        do_reset();
        imem_ready = 0; D_valid = 1; D_is_jr = 1; D_rs_data = 32'h0000_4000;
        tick();
        clear_d();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (redirect_pending !== 1'b1 || F_PC !== 32'h0000_3000)
                $display("FAIL pend_hold[%0d]: got pend=%b pc=%h want pend=1 pc=00003000",
                         i, redirect_pending, F_PC);
            else passed++;
            if (i < 3) tick();
        end
        imem_ready = 1;
        tick();
        total++;
        if (F_PC !== 32'h0000_4000 || redirect_pending !== 1'b0)
            $display("FAIL pend_apply: got pc=%h pend=%b want pc=00004000 pend=0", F_PC, redirect_pending);
        else passed++;
    endtask

    task automatic test_stall_mask();
        do_reset();
        stall = 1; D_valid = 1; D_is_beq = 1; Beq_judge = 1; D_PC = 32'h0000_3000; D_imm16 = 16'h0003;
        #1;
        total++;
        if (F_fire !== 1'b0) $display("FAIL stall_fire: got %b want 0", F_fire);
        else passed++;
        tick();
        total++;
        if (F_PC !== 32'h0000_3000 || redirect_pending !== 1'b0)
            $display("FAIL stall_hold: got pc=%h pend=%b want pc=00003000 pend=0", F_PC, redirect_pending);
        else passed++;
        stall = 0;
        tick();
        total++;
        if (F_PC !== 32'h0000_3010) $display("FAIL stall_release: got %h want 00003010", F_PC);
        else passed++;
        clear_d();
    endtask

    task automatic test_reset_in_pend();
        do_reset();
        imem_ready = 0; D_valid = 1; D_is_jr = 1; D_rs_data = 32'h0000_5000;
        tick();
        total++;
        if (redirect_pending !== 1'b1) $display("FAIL rip_enter: got %b want 1", redirect_pending);
        else passed++;
        reset = 1; stall = 1; imem_ready = 1;
        tick();
        total++;
        if (F_PC !== 32'h0000_3000 || redirect_pending !== 1'b0)
            $display("FAIL rip_reset: got pc=%h pend=%b want pc=00003000 pend=0", F_PC, redirect_pending);
        else passed++;
        reset = 0; stall = 0; clear_d();
        tick();
        total++;
        if (F_PC !== 32'h0000_3004) $display("FAIL rip_discard: got %h want 00003004", F_PC);
        else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int unsigned sel;
            reset      = ($urandom_range(0, 49) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            imem_ready = ($urandom_range(0, 2) != 0);
            D_valid    = ($urandom_range(0, 3) != 0);
            sel        = $urandom_range(0, 4);
            D_is_beq   = (sel == 1);
            D_is_bne   = (sel == 2);
            D_is_j     = (sel == 3);
            D_is_jr    = (sel == 4);
            Beq_judge  = 1'($urandom);
            Bne_judge  = 1'($urandom);
            D_PC       = $urandom & 32'hFFFF_FFFC;
            D_imm16    = 16'($urandom);
            D_imm26    = 26'($urandom);
            D_rs_data  = $urandom;
            #1;
            total++;
            if (F_fire !== m_fire()) $display("FAIL rnd_fire[%0d]: got %b want %b", n, F_fire, m_fire());
            else passed++;
            tick();
            total++;
            if (F_PC !== m_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", n, F_PC, m_pc);
            else passed++;
            total++;
            if (redirect_pending !== (m_q.size() != 0))
                $display("FAIL rnd_pend[%0d]: got %b want %b", n, redirect_pending, m_q.size() != 0);
            else passed++;
        end
        reset = 0; clear_d();
    endtask

    initial begin
        m_pc = 32'h0000_3000;
        reset = 1; stall = 0; imem_ready = 0; clear_d();
        @(negedge clk);
        test_reset();
        test_beq_taken();
        test_bne_wrap();
        test_pending();
        test_stall_mask();
        test_reset_in_pend();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
